// File: rtl/uart_tx_scheduler.sv
// Byte FIFO and send sequencer in front of the UART transmitter: queues bus writes and issues one tx_send per byte.
// Optional UART_TX_SCHED_OVERFLOW_EN adds a sticky overflow flag (dropped write or ack timeout) with overflow_clr.
module uart_tx_scheduler #(
  parameter int DEPTH       = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       uart_busy,
`ifdef UART_TX_SCHED_OVERFLOW_EN
  input  logic                       overflow_clr,
  output logic                       overflow,
`endif
  output logic                       tx_send,
  output logic [DATA_WIDTH-1:0]      tx_data,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       sched_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(ACK_TIMEOUT+1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, count_nxt;
  logic [TW-1:0]         tcnt;
  state_t                state;
  logic                  push, pop, drop, ack_to;

  // Full is judged on the registered flag, so a pop in the same cycle never frees room for a write.
  assign push   = wr_en && !fifo_full;
  assign drop   = wr_en &&  fifo_full;
  assign pop    = (state == IDLE) && !fifo_empty;
  assign ack_to = (state == WAIT_ACK) && !uart_busy && (tcnt == TW'(ACK_TIMEOUT-1));

  assign fifo_count = count;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      state      <= IDLE;
      tx_send    <= 1'b0;
      tx_data    <= '0;
      sched_busy <= 1'b0;
      tcnt       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count      <= count_nxt;
      fifo_empty <= (count_nxt == '0);
      fifo_full  <= (count_nxt == CW'(DEPTH));
      tx_send    <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data    <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 1'b1;
            tx_send    <= 1'b1;
            sched_busy <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          tcnt  <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (uart_busy) begin
            state <= WAIT_DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
            // UART never acknowledged: the byte is abandoned, no retry.
            if (ack_to) begin
              state      <= IDLE;
              sched_busy <= 1'b0;
            end
          end
        end
        WAIT_DONE: begin
          if (!uart_busy) begin
            state      <= IDLE;
            sched_busy <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          sched_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_TX_SCHED_OVERFLOW_EN
  // Set has priority over clear so an event coinciding with a clear is not lost.
  always_ff @(posedge clk) begin
    if (rst)                 overflow <= 1'b0;
    else if (drop || ack_to) overflow <= 1'b1;
    else if (overflow_clr)   overflow <= 1'b0;
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: UART busy model, byte scoreboard, immediate-assertion checks.
module tb_uart_tx_scheduler;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       uart_busy = 1'b0;
  logic       tx_send;
  logic [7:0] tx_data;
  logic       fifo_full, fifo_empty, sched_busy;
  logic [4:0] fifo_count;
`ifdef UART_TX_SCHED_OVERFLOW_EN
  logic       overflow;
  logic       overflow_clr = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int n_sends = 0;
  int max_cnt = 0;
  logic [7:0] sb [$];

  // UART model: 0 = normal (busy ack_dly ticks after tx_send, for frame_len ticks), 1 = tied low, 2 = held high
  int mode = 1;
  int ack_dly = 2;
  int frame_len = 20;
  int dly = 0;
  int frm = 0;

  uart_tx_scheduler #(.DEPTH(DEPTH), .DATA_WIDTH(8), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .uart_busy(uart_busy),
`ifdef UART_TX_SCHED_OVERFLOW_EN
    .overflow_clr(overflow_clr), .overflow(overflow),
`endif
    .tx_send(tx_send), .tx_data(tx_data), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_count(fifo_count), .sched_busy(sched_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    case (mode)
      1: uart_busy = 1'b0;
      2: uart_busy = 1'b1;
      default: begin
        if (dly > 0) begin
          dly--;
          if (dly == 0) frm = frame_len;
        end else if (frm > 0) frm--;
        if (tx_send === 1'b1) dly = ack_dly;
        uart_busy = (frm > 0);
      end
    endcase
  end

  // Scoreboard consumer: every tx_send must match the oldest expected byte.
  always @(negedge clk) begin
    if (tx_send === 1'b1) begin
      n_sends++;
      if (sb.size() == 0) chk("tx_send_unexpected", 32'(tx_send), 32'd0);
      else chk("tx_data_order", 32'(tx_data), 32'(sb.pop_front()));
    end
    if (!rst && int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
  end

  task automatic write_byte(input logic [7:0] b, input bit expect_accept);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = b;
    if (expect_accept) sb.push_back(b);
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (!(fifo_empty === 1'b1 && sched_busy === 1'b0 && uart_busy === 1'b0) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle_in_time"}, 32'(n < max), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int sends0;

    // Reset with a write held active: nothing may be queued.
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'hAA; mode = 1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_tx_send", 32'(tx_send), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_empty", 32'(fifo_empty), 32'd1);
      chk("rst_full", 32'(fifo_full), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_sched_busy", 32'(sched_busy), 32'd0);
    end
    @(negedge clk); rst = 1'b0; wr_en = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_empty", 32'(fifo_empty), 32'd1);
    chk("post_rst_sends", 32'(n_sends), 32'd0);

    // Single byte: tx_send in the second cycle after the write edge.
    mode = 0; ack_dly = 2; frame_len = 20;
    write_byte(8'h41, 1'b1);
    @(negedge clk);
    chk("single_send_early", 32'(tx_send), 32'd0);
    chk("single_empty_clear", 32'(fifo_empty), 32'd0);
    @(negedge clk);
    chk("single_send", 32'(tx_send), 32'd1);
    chk("single_data", 32'(tx_data), 32'h41);
    @(negedge clk);
    chk("single_send_pulse", 32'(tx_send), 32'd0);
    n = 0;
    while (uart_busy !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    chk("single_busy_rose", 32'(uart_busy), 32'd1);
    n = 0;
    while (uart_busy === 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("single_busy_while_frame", 32'(sched_busy), 32'd1);
    @(negedge clk);
    chk("single_sched_idle", 32'(sched_busy), 32'd0);
    chk("single_sb_drained", 32'(sb.size()), 32'd0);

    // Ack timeout: busy never rises, FSM gives up after 15 WAIT_ACK cycles.
    mode = 1;
    write_byte(8'h55, 1'b1);
    n = 0;
    while (tx_send !== 1'b1 && n < 6) begin @(negedge clk); n++; end
    chk("to_send_seen", 32'(tx_send), 32'd1);
    n = 0;
    while (sched_busy === 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("to_busy_cycles", 32'(n), 32'd16);
    sends0 = n_sends;
    repeat (30) @(negedge clk);
    chk("to_no_retry", 32'(n_sends), 32'(sends0));
    chk("to_sched_idle", 32'(sched_busy), 32'd0);
`ifdef UART_TX_SCHED_OVERFLOW_EN
    chk("to_overflow_set", 32'(overflow), 32'd1);
    overflow_clr = 1'b1;
    @(negedge clk); overflow_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
`endif

    // Full: with busy held, the first byte goes in flight and frees a slot,
    // so 16 more fit and the 18th write is the first one dropped.
    mode = 2;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 18; i++) write_byte(8'(i), i < 17);
    @(negedge clk);
    chk("full_flag", 32'(fifo_full), 32'd1);
    chk("full_count", 32'(fifo_count), 32'd16);
`ifdef UART_TX_SCHED_OVERFLOW_EN
    chk("full_overflow", 32'(overflow), 32'd1);
`endif
    mode = 0; ack_dly = 1; frame_len = 4;
    wait_idle("full_drain", 1000);
    chk("full_sb_drained", 32'(sb.size()), 32'd0);

    // Wrap-around stream, throttled on fifo_full, pops often coincide with writes.
    frame_len = 3;
    sends0 = n_sends;
    for (int i = 0; i < 40; i++) begin
      n = 0;
      @(negedge clk);
      while (fifo_full === 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) chk("wrap_full_stuck", 32'(fifo_full), 32'd0);
      wr_en = 1'b1; wr_data = 8'(8'h80 + i); sb.push_back(8'(8'h80 + i));
      @(posedge clk); #1 wr_en = 1'b0;
      if (i % 9 == 4) repeat (3) @(negedge clk);
    end
    wait_idle("wrap_drain", 2000);
    chk("wrap_recv_count", 32'(n_sends - sends0), 32'd40);
    chk("wrap_sb_drained", 32'(sb.size()), 32'd0);
    chk("max_count_le_depth", 32'(max_cnt <= DEPTH), 32'd1);

    // Reset in WAIT_DONE with 5 bytes queued discards everything.
    mode = 2;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) write_byte(8'(8'hC0 + i), 1'b1);
    @(negedge clk);
    chk("midrst_count", 32'(fifo_count), 32'd5);
    chk("midrst_busy", 32'(sched_busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    chk("midrst_empty", 32'(fifo_empty), 32'd1);
    chk("midrst_count0", 32'(fifo_count), 32'd0);
    chk("midrst_sched", 32'(sched_busy), 32'd0);
    @(negedge clk); rst = 1'b0; mode = 0;
    sends0 = n_sends;
    repeat (30) @(negedge clk);
    chk("midrst_no_send", 32'(n_sends), 32'(sends0));
    chk("midrst_still_empty", 32'(fifo_empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
